program_loader: RTL
===================

# program_loader

Boot-time loader that sits directly upstream of the BIP processor's program memory. It assembles 16-bit instruction words from UART receive bytes, writes them into program memory at consecutive addresses and holds the processor in reset while loading. On a HLT word (opcode 0) or a full memory, it sends a one-byte acknowledge over UART and releases the processor.

## Interface
Parameters:
- BITS, 16, instruction word width
- DTBITS, BITS-5 (11), program memory address width
- OPBITS, BITS-DTBITS (5), opcode field width (word bits [BITS-1:DTBITS])
- BYTE, 8, UART data width

Ports:
- i_clock  in  1  system clock; all state changes on the rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_rx_data  in  BYTE  received UART byte, valid when i_rx_done=1
- i_rx_done  in  1  one-cycle pulse, one new byte
- i_tx_done  in  1  one-cycle pulse, UART transmitter finished the byte
- o_tx_start  out  1  one-cycle pulse, start transmitting o_tx_data
- o_tx_data  out  BYTE  acknowledge byte = words written, low 8 bits
- o_prog_we  out  1  program memory write strobe, one cycle per word
- o_prog_addr  out  DTBITS  program memory write address
- o_prog_data  out  BITS  program memory write data
- o_cpu_reset  out  1  processor reset, high while not in RUN
- o_loaded  out  1  high in RUN

## Operation
- States: LO (await low byte), HI (await high byte), WR (write word), ACK (acknowledge), RUN.
- Reset: state LO, address counter 0, word counter 0 (DTBITS+1 bits), byte latch 0. Output reset values: o_prog_we=0, o_prog_addr=0, o_prog_data=0, o_tx_start=0, o_tx_data=0, o_cpu_reset=1, o_loaded=0.
- LO: on i_rx_done, latch i_rx_data as word[7:0], go to HI.
- HI: on i_rx_done, latch i_rx_data as word[15:8], go to WR.
- WR (exactly one cycle):
  - o_prog_we=1, o_prog_addr=address counter, o_prog_data=assembled word.
  - Word counter increments.
  - Terminal write if the opcode field word[15:11]==0 (HLT) or address==2^DTBITS-1: go to ACK, address unchanged.
  - Otherwise: address increments, go to LO.
- The HLT word is itself written and counted.
- ACK:
  - o_tx_data = word counter[7:0], driven throughout ACK.
  - o_tx_start=1 on the first ACK cycle only.
  - Stay until i_tx_done, then go to RUN.
- RUN: o_cpu_reset=0, o_loaded=1. All rx bytes ignored. Leave RUN only through i_reset.
- i_rx_done in WR, ACK or RUN: ignored. The UART byte spacing (≥ 10 bit times) guarantees no byte lands in WR.
- i_tx_done outside ACK: ignored.
- Reset mid-load or in RUN: immediate return to the reset values. Words already in memory are not erased; the reload starts again at address 0.

## Timing
- Byte 2 of a word with i_rx_done at edge k: WR is active in cycle k+1, o_prog_we high for exactly that one cycle, memory write at edge k+2.
- Non-terminal word: in LO at cycle k+2, ready for the next byte.
- Terminal word: ACK entered at k+2, o_tx_start high in cycle k+2 only.
- i_tx_done at edge j: RUN from cycle j+1, so o_cpu_reset falls and o_loaded rises in the same cycle.
- o_prog_addr and o_prog_data are registered and stable for the whole WR cycle.
- o_cpu_reset is registered and glitch-free.

## Test plan
- Reset values: assert i_reset mid-cycle (asynchronous) -> all outputs at their reset values immediately, o_cpu_reset=1.
- Three-word load: bytes 0x05,0x08 / 0x07,0x18 / 0x00,0x00 -> writes 0x0805@0, 0x1807@1, 0x0000@2, one we pulse each. Then o_tx_start pulse with o_tx_data=0x03. After i_tx_done, o_cpu_reset=0 and o_loaded=1 next cycle.
- HLT detection on opcode only: word 0x07FF (opcode 0, operand nonzero) at address 0 -> written and treated as terminal; o_tx_data=0x01.
- Memory full: 2048 non-HLT words (e.g. 0x0801) -> last write at address 0x7FF, then ACK with o_tx_data=0x00 (count 2048, low byte). No address wrap, no 2049th write.
- Ignored input: extra rx bytes during ACK and RUN -> no o_prog_we, counters unchanged. Spurious i_tx_done while in LO -> no state change.
- Reset mid-word: low byte received, then i_reset -> state LO, address 0. The next two bytes form a word written at address 0.

Source files
------------

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module   : program_loader
// Brief    : Boot loader assembling UART bytes into program words, writing
//            them to program memory and releasing the CPU after an ack byte.
// Revision : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int BITS   = 16,
    parameter int DTBITS = BITS - 5,
    parameter int OPBITS = BITS - DTBITS,
    parameter int BYTE   = 8
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [BYTE-1:0]   i_rx_data,
    input  logic              i_rx_done,
    input  logic              i_tx_done,
    output logic              o_tx_start,
    output logic [BYTE-1:0]   o_tx_data,
    output logic              o_prog_we,
    output logic [DTBITS-1:0] o_prog_addr,
    output logic [BITS-1:0]   o_prog_data,
    output logic              o_cpu_reset,
    output logic              o_loaded
);

    localparam logic [2:0] c_LO  = 3'd0;
    localparam logic [2:0] c_HI  = 3'd1;
    localparam logic [2:0] c_WR  = 3'd2;
    localparam logic [2:0] c_ACK = 3'd3;
    localparam logic [2:0] c_RUN = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [DTBITS-1:0] r_addr;
    logic [DTBITS:0]   r_wcount;
    logic [DTBITS:0]   w_wcount_next;
    logic [BITS-1:0]   r_word;
    logic [OPBITS-1:0] w_opcode;
    logic              w_terminal;

    logic              w_we_d;
    logic              w_tx_start_d;
    logic [BYTE-1:0]   w_tx_data_d;
    logic              w_cpu_reset_d;
    logic              w_loaded_d;

    logic              r_we;
    logic              r_tx_start;
    logic [BYTE-1:0]   r_tx_data;
    logic              r_cpu_reset;
    logic              r_loaded;

    assign w_opcode      = r_word[BITS-1:DTBITS];
    assign w_terminal    = (w_opcode == '0) || (r_addr == {DTBITS{1'b1}});
    assign w_wcount_next = (r_state == c_WR) ? r_wcount + 1'b1 : r_wcount;

    // State register
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= c_LO;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_LO:    if (i_rx_done) w_next_state = c_HI;
            c_HI:    if (i_rx_done) w_next_state = c_WR;
            c_WR:    w_next_state = w_terminal ? c_ACK : c_LO;
            c_ACK:   if (i_tx_done) w_next_state = c_RUN;
            c_RUN:   w_next_state = c_RUN;
            default: w_next_state = c_LO;
        endcase
    end

    // Outputs are computed from the upcoming state and registered, so each
    // strobe lines up with the state it belongs to and cannot glitch.
    always_comb begin
        w_we_d        = (w_next_state == c_WR);
        w_tx_start_d  = (r_state == c_WR) && (w_next_state == c_ACK);
        w_tx_data_d   = (w_next_state == c_ACK) ? w_wcount_next[BYTE-1:0] : '0;
        w_cpu_reset_d = (w_next_state != c_RUN);
        w_loaded_d    = (w_next_state == c_RUN);
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_we        <= 1'b0;
            r_tx_start  <= 1'b0;
            r_tx_data   <= '0;
            r_cpu_reset <= 1'b1;
            r_loaded    <= 1'b0;
        end else begin
            r_we        <= w_we_d;
            r_tx_start  <= w_tx_start_d;
            r_tx_data   <= w_tx_data_d;
            r_cpu_reset <= w_cpu_reset_d;
            r_loaded    <= w_loaded_d;
        end
    end

    // Address holds on the terminal write so the last address is never wrapped.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_addr   <= '0;
            r_wcount <= '0;
            r_word   <= '0;
        end else begin
            r_wcount <= w_wcount_next;
            if (r_state == c_LO && i_rx_done) begin
                r_word[BYTE-1:0] <= i_rx_data;
            end
            if (r_state == c_HI && i_rx_done) begin
                r_word[BITS-1:BYTE] <= i_rx_data[BITS-BYTE-1:0];
            end
            if (r_state == c_WR && !w_terminal) begin
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    assign o_prog_we   = r_we;
    assign o_prog_addr = r_addr;
    assign o_prog_data = r_word;
    assign o_tx_start  = r_tx_start;
    assign o_tx_data   = r_tx_data;
    assign o_cpu_reset = r_cpu_reset;
    assign o_loaded    = r_loaded;

endmodule
`default_nettype wire
